// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// The helpers work on a fixed wide vector so any arbiter width up to
// RR_MAX_N can use them; callers widen their inputs and narrow the results.
package rr_arb_pkg;

   localparam int RR_MAX_N    = 64;
   localparam int RR_MAX_ID_W = $clog2(RR_MAX_N);

   typedef logic [RR_MAX_N-1:0] rr_vec_t;

   // Arbiter control state: either nothing is granted or one requester owns the resource
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_state_e;

   // Rotate the low n bits of v left by one position, bit n-1 wrapping to bit 0
   function automatic rr_vec_t rotl1(input rr_vec_t v, input int n);
      rr_vec_t r;
      r = '0;
      for (int i = 0; i < RR_MAX_N; i++) begin
         if (i < n) begin
            r[(i + 1) % n] = v[i];
         end
      end
      return r;
   endfunction

   // Binary index of the set bit in a one-hot vector; zero for an all-zero vector
   function automatic logic [RR_MAX_ID_W-1:0] onehot2bin(input rr_vec_t v);
      logic [RR_MAX_ID_W-1:0] b;
      b = '0;
      for (int i = 0; i < RR_MAX_N; i++) begin
         if (v[i]) begin
            b = b | RR_MAX_ID_W'(i);
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: the first requester at or above the one-hot
// priority position wins, wrapping from the top bit back to bit 0.
module rr_pick #(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] prio_i,
   output logic [N-1:0] winner_o,
   output logic         found_o
);

   logic [2*N-1:0] masked;
   logic [2*N-1:0] isolated;

   // The lower copy only keeps requests at or above the priority bit; the upper
   // copy holds every request so a scan that runs past the top wraps naturally.
   // Isolating the lowest set bit of the doubled vector gives the circular winner.
   always_comb begin
      masked   = {req_i, req_i & ~(prio_i - N'(1))};
      isolated = masked & (~masked + (2*N)'(1));
      winner_o = isolated[N-1:0] | isolated[2*N-1:N];
      found_o  = |req_i;
   end

endmodule

// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters. A one-hot
// priority pointer rotates past each released or pre-empted winner, grants
// are held while the owner keeps requesting, and a hold timeout forces the
// resource to move on after MAX_HOLD consecutive cycles.
module one_hot_rr_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16,
   parameter int ID_W     = $clog2(N),
   parameter int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [ID_W-1:0] grant_id,
   output logic [N-1:0]    prio,
   output logic            timeout
);

   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   rr_state_e       state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [N-1:0]    prio_q, prio_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic            timeout_q, timeout_d;

   logic            ownReq;
   logic            holdExpired;
   logic            keepGrant;
   logic            moving;
   logic [N-1:0]    rotGrant;
   logic [N-1:0]    pickPrio;
   logic [N-1:0]    winner;
   logic            found;
   logic [ID_W-1:0] winnerId;

   // Decide whether the current owner keeps the resource this edge, and work out
   // the rotated pointer the re-pick must use when it does not. The picker sees
   // the rotated pointer on a release/timeout edge so newcomers compete fairly.
   always_comb begin
      ownReq      = |(req & grant_q);
      holdExpired = (MAX_HOLD != 0) && (hold_q == HoldLast);
      keepGrant   = ownReq && !holdExpired;
      moving      = (state_q == GRANT) && !keepGrant;
      rotGrant    = N'(rotl1(RR_MAX_N'(grant_q), N));
      pickPrio    = moving ? rotGrant : prio_q;
      winnerId    = ID_W'(onehot2bin(RR_MAX_N'(winner)));
   end

   rr_pick #(
      .N(N)
   ) u_pick (
      .req_i   (req),
      .prio_i  (pickPrio),
      .winner_o(winner),
      .found_o (found)
   );

   // Next-state logic: issue from IDLE, then in GRANT either hold (counting
   // cycles) or hand over on release/timeout with a same-edge re-pick, dropping
   // back to IDLE when nothing can be granted or new grants are disabled.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      prio_d    = prio_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (enable && found) begin
               grant_d = winner;
               id_d    = winnerId;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (keepGrant) begin
               if (MAX_HOLD != 0) begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end else begin
               timeout_d = ownReq;
               prio_d    = rotGrant;
               hold_d    = '0;
               if (enable && found) begin
                  grant_d = winner;
                  id_d    = winnerId;
               end else begin
                  grant_d = '0;
                  id_d    = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
         end
      endcase
   end

   // State register with synchronous reset; reset drops any grant silently and
   // returns the priority pointer to bit 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         prio_q    <= N'(1);
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         prio_q    <= prio_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   // Registered outputs straight from state
   always_comb begin
      grant       = grant_q;
      grant_valid = |grant_q;
      grant_id    = id_q;
      prio        = prio_q;
      timeout     = timeout_q;
   end

endmodule

// File: tb/tb_one_hot_rr_arbiter.sv
// Self-checking bench for the round-robin arbiter: directed scenarios followed
// by random requests, all compared against an index-based reference model.
module tb_one_hot_rr_arbiter;

   localparam int N        = 8;
   localparam int MAX_HOLD = 4;
   localparam int ID_W     = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            enable;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [ID_W-1:0] grant_id;
   logic [N-1:0]    prio;
   logic            timeout;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;

   // Reference model: owner index (-1 when none), priority index, number of
   // cycles the current grant has been visible, and the timeout pulse.
   int mOwner   = -1;
   int mPrioIdx = 0;
   int mHeld    = 0;
   bit mTimeout = 1'b0;

   // Free-running clock
   always #5 clock = ~clock;

   one_hot_rr_arbiter #(
      .N(N),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .req        (req),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .prio       (prio),
      .timeout    (timeout)
   );

   function automatic int pickWinner(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (from + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] modelGrant();
      logic [N-1:0] one;
      one = N'(1);
      return (mOwner < 0) ? '0 : (one << mOwner);
   endfunction

   task automatic modelStep(input logic rs, input logic en, input logic [N-1:0] r);
      int w;
      mTimeout = 1'b0;
      if (rs) begin
         mOwner   = -1;
         mPrioIdx = 0;
         mHeld    = 0;
      end else if (mOwner < 0) begin
         w = en ? pickWinner(r, mPrioIdx) : -1;
         if (w >= 0) begin
            mOwner = w;
            mHeld  = 1;
         end
      end else if (r[mOwner] && (MAX_HOLD == 0 || mHeld < MAX_HOLD)) begin
         mHeld++;
      end else begin
         mTimeout = r[mOwner];
         mPrioIdx = (mOwner + 1) % N;
         w = en ? pickWinner(r, mPrioIdx) : -1;
         mOwner = w;
         mHeld  = (w >= 0) ? 1 : 0;
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [N-1:0] expGrant;
      logic [N-1:0] one;
      one      = N'(1);
      expGrant = modelGrant();
      checkVal({tag, ".grant"}, 32'(grant), 32'(expGrant));
      checkVal({tag, ".grant_valid"}, 32'(grant_valid), 32'(mOwner >= 0));
      checkVal({tag, ".grant_id"}, 32'(grant_id), (mOwner < 0) ? 32'd0 : 32'(mOwner));
      checkVal({tag, ".prio"}, 32'(prio), 32'(one << mPrioIdx));
      checkVal({tag, ".timeout"}, 32'(timeout), 32'(mTimeout));
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic en, input logic rs, input string tag);
      req    = r;
      enable = en;
      reset  = rs;
      @(posedge clock);
      modelStep(rs, en, r);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [N-1:0] one;
      logic [N-1:0] r;
      logic         en;
      logic         rs;
      one    = N'(1);
      reset  = 1'b1;
      enable = 1'b0;
      req    = '0;
      #2;

      // Reset with every request high, then the first grant goes to bit 0
      applyStimulus(8'hFF, 1'b1, 1'b1, "reset0");
      applyStimulus(8'hFF, 1'b1, 1'b1, "reset1");
      checkVal("resetGrant", 32'(grant), 32'h00);
      checkVal("resetPrio", 32'(prio), 32'h01);
      applyStimulus(8'hFF, 1'b1, 1'b0, "firstGrant");
      checkVal("firstGrantVec", 32'(grant), 32'h01);
      checkVal("firstGrantId", 32'(grant_id), 32'd0);

      // Rotation fairness: each owner drops its bit after one cycle
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'hFF & ~modelGrant(), 1'b1, 1'b0, "rotate");
         checkVal("rotateGrant", 32'(grant), 32'(one << ((i + 1) % N)));
         checkVal("rotatePrio", 32'(prio), 32'(one << ((i + 1) % N)));
      end

      // Circular pick: steer prio to bit 5, then bit 0 must beat bit 3
      applyStimulus(8'h00, 1'b1, 1'b0, "drain");
      applyStimulus(8'h10, 1'b1, 1'b0, "grant4");
      applyStimulus(8'h00, 1'b1, 1'b0, "release4");
      checkVal("prioAt5", 32'(prio), 32'h20);
      applyStimulus(8'h09, 1'b1, 1'b0, "circPick");
      checkVal("circPickGrant", 32'(grant), 32'h01);
      applyStimulus(8'h08, 1'b1, 1'b0, "circRelease");
      checkVal("circReleasePrio", 32'(prio), 32'h02);
      checkVal("circReleaseGrant", 32'(grant), 32'h08);
      applyStimulus(8'h00, 1'b1, 1'b0, "circDrain");

      // Timeout with two contenders: bit 1 held four cycles, then bit 2
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'h06, 1'b1, 1'b0, "timeoutPair");
         if (i == 4) begin
            checkVal("pairTimeoutPulse", 32'(timeout), 32'h1);
            checkVal("pairTimeoutGrant", 32'(grant), 32'h04);
         end
      end
      applyStimulus(8'h00, 1'b1, 1'b0, "pairDrain");

      // Lone requester is re-granted on every timeout
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'h02, 1'b1, 1'b0, "timeoutLone");
         if (i == 4 || i == 8) begin
            checkVal("loneTimeoutPulse", 32'(timeout), 32'h1);
            checkVal("loneTimeoutGrant", 32'(grant), 32'h02);
         end
      end
      applyStimulus(8'h00, 1'b1, 1'b0, "loneDrain");

      // Enable gating: existing grant survives, no re-pick until enable returns
      applyStimulus(8'h03, 1'b1, 1'b0, "gateGrant");
      applyStimulus(8'h03, 1'b0, 1'b0, "gateHold0");
      applyStimulus(8'h03, 1'b0, 1'b0, "gateHold1");
      applyStimulus(8'h02, 1'b0, 1'b0, "gateRelease");
      checkVal("gateReleaseGrant", 32'(grant), 32'h00);
      applyStimulus(8'h02, 1'b0, 1'b0, "gateIdle");
      applyStimulus(8'h02, 1'b1, 1'b0, "gateResume");
      checkVal("gateResumeGrant", 32'(grant), 32'h02);
      applyStimulus(8'h00, 1'b1, 1'b0, "gateDrain");

      // Reset in the middle of a grant
      applyStimulus(8'h10, 1'b1, 1'b0, "midGrant");
      checkVal("midGrantVec", 32'(grant), 32'h10);
      applyStimulus(8'h10, 1'b1, 1'b1, "midReset");
      checkVal("midResetGrant", 32'(grant), 32'h00);
      checkVal("midResetPrio", 32'(prio), 32'h01);
      checkVal("midResetTimeout", 32'(timeout), 32'h0);
      applyStimulus(8'h00, 1'b1, 1'b0, "postReset");

      // Random traffic: requests mostly persist, owners drop out now and then
      r = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) r = r & ~modelGrant();
         en = ($urandom_range(0, 7) != 0);
         rs = ($urandom_range(0, 99) == 0);
         applyStimulus(r, en, rs, "random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/one_hot_rr_arbiter.md
Name: one_hot_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a rotating one-hot pointer that advances exactly like the team's 8-bit one-hot counter.
- Issues a one-hot grant, holds it while the winner keeps requesting, and pre-empts on a hold timeout.
- Sits between the requester blocks and the shared datapath; the datapath mux selects with grant_id.

Parameters:
- N, 8, number of requesters; must be ≥ 2.
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the timeout.
- ID_W, $clog2(N), width of grant_id.
- HOLD_W, $clog2(MAX_HOLD+1), width of the hold counter.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new grant is issued; an existing grant continues.
- req  input  N  request vector, level-sensitive; a requester holds its bit high for as long as it wants the resource.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  equals |grant.
- grant_id  output  ID_W  binary index of the granted bit; 0 when no grant is held.
- prio  output  N  one-hot priority pointer; the highest-priority position.
- timeout  output  1  one-cycle pulse on the edge where a grant is pre-empted.

Behaviour:
- Reset (sampled at a clock edge): grant=0, grant_valid=0, grant_id=0, prio=1 (bit 0), timeout=0, hold_cnt=0, state=IDLE.
- Reset mid-grant drops the grant on that edge; no timeout pulse is produced.
- Pick function: winner = first set bit of req, scanning circularly from the prio bit upward (bit N-1 wraps to bit 0). No request gives no winner.
- IDLE state:
  - If enable=1 and |req=1, register grant=onehot(winner) and grant_id=winner; go to GRANT.
  - Latency is one cycle: req sampled at edge k gives grant visible after edge k.
  - hold_cnt=0.
- GRANT state, evaluated each edge:
  - Hold: req[grant_id]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1). Grant unchanged; hold_cnt increments.
  - Release: req[grant_id]=0. prio becomes grant rotated left by 1 (bit N-1 wraps to bit 0). The rotated prio is used for the same-edge re-pick.
  - Timeout: req[grant_id]=1 and hold_cnt=MAX_HOLD-1. Same prio rotation as release; timeout=1 for one cycle.
  - On release or timeout, if enable=1 and a winner exists under the new prio, grant moves to that winner on the same edge. There is no bubble, and hold_cnt resets to 0.
  - Otherwise grant=0 and the state returns to IDLE.
  - If the pre-empted requester is the only requester, it is re-granted on the same edge with hold_cnt=0.
- enable=0 while in GRANT: the current grant is held and timeouts still fire, but no re-pick occurs, so the arbiter returns to IDLE.
- prio changes only on release or timeout; it never changes while idle.
- A grant is therefore held for at most MAX_HOLD consecutive cycles.
- Invariants:
  - grant is one-hot or zero.
  - A newly issued grant targets a bit that was high in req at the issuing edge.
  - prio is always one-hot.
  - With all requests held high, each requester is granted once per N grants.
- Simultaneous events: a request arriving on the release edge competes under the new prio. Requests from non-granted bits never disturb a held grant.

Decomposition:
- Shared package rr_arb_pkg holds:
  - the state enum {IDLE, GRANT};
  - the rotate-left-by-one function used for prio;
  - the one-hot-to-binary encode function.
- One combinational sub-module, rr_pick (parameter N): inputs req and prio; outputs winner one-hot and found flag.
  - Implementation is a double-width masked priority scan.
  - It is instantiated once and fed the current prio or the rotated prio, selected by a mux.

Test Plan:
- Reset/idle: reset high for 2 edges with req=8'hFF → grant=0, prio=8'h01. Release reset with enable=1 → after 1 edge grant=8'h01, grant_id=0.
- Rotation fairness: req=8'hFF held; each granted requester drops its bit for one cycle after 1 cycle of grant → grant sequence 01,02,04,…,80,01 (wrap); prio one step ahead each time.
- Circular pick: prio=8'h20, req=8'h09 → grant=8'h01 (bit 0 beats bit 3, since scan order is 5,6,7,0,…). Release it → prio=8'h02, next grant=8'h08.
- Timeout, MAX_HOLD=4: req=8'h06 held, bit 1 granted → grant=02 for 4 cycles, then timeout pulse and grant=04 on the same edge. Lone req=8'h02 → re-granted 02 with a timeout pulse every 4 cycles.
- Enable gating: grant held and enable dropped → grant stays until req bit falls, then grant=0 and IDLE with other reqs pending. Raising enable → grant after 1 edge.
- Reset mid-grant: grant=8'h10 and reset pulsed for 1 edge → grant=0, prio=8'h01, timeout=0 the following cycle.
